keypad_code_engine: RTL and testbench
=====================================

# keypad_code_engine

Sequencing datapath behind the keylock state machine. It collects digit key presses into an entry buffer and holds the passcode (PC), the active user code (UC) and a pending candidate UC. It produces the `match` and `ValidNewUC` qualifiers that the keylock FSM samples on command keys. It also commits new user codes and tracks lock status from the FSM's state-bit outputs.

## Interface
- `CODE_LEN`, 4: digits per code; code width is 4*CODE_LEN bits.
- `PASSCODE`, 16'h1234: fixed programming passcode, 4*CODE_LEN bits.
- `DEFAULT_UC`, 16'h5AB0: user code loaded at reset.
- `LOCKOUT_CYCLES`, 1000: lockout duration in clocks (only with `CODE_LOCKOUT_EN`).
- `clk` in 1: single clock, rising edge.
- `resetN` in 1: asynchronous, active-low reset.
- `rdy` in 1: one-cycle key-valid strobe.
- `keypress` in 4: key code, qualified by `rdy`.
- `CheckPC`, `CheckValidUC`, `confirmUC`, `LOCKING`, `ToggleLED1`, `Chillin`, `error` in 1 each: FSM state-bit outputs.
- `match` out 1: entry equals the selected target (combinational from registers).
- `ValidNewUC` out 1: entry is an acceptable new UC (combinational from registers).
- `locked` out 1: current lock status.
- `entry_cnt` out $clog2(CODE_LEN+1): digits currently buffered.
- `lockout` out 1: entry disabled (tied 0 without the macro).

## Operation
- Command keys: 7 = cancel, 8 = program, 9 = lock/unlock. All other values are digits.
- Mode decode, highest priority first: `CheckPC` → PC; `CheckValidUC` → VALID; `confirmUC` → CONFIRM; `LOCKING` → UC; otherwise IDLE.
- Entry buffer is a shift register. On `rdy` with a digit in a non-IDLE mode, the buffer shifts left 4 bits, the new digit enters the low nibble, and `entry_cnt` increments.
- At `entry_cnt == CODE_LEN`, a further digit sets the sticky `ovf` flag. The buffer and `entry_cnt` are held.
- Clear of buffer, `entry_cnt` and `ovf` occurs on:
  - `rdy` with any command key;
  - any mode change, detected against the registered previous mode;
  - IDLE mode.
- `match` = (`entry_cnt == CODE_LEN`) & !`ovf` & (buffer == target).
  - Target is PASSCODE in PC mode, UC register in UC mode, candidate register in CONFIRM mode.
  - `match` is 0 in VALID and IDLE modes.
- `ValidNewUC` = VALID mode & `entry_cnt == CODE_LEN` & !`ovf` & buffer != PASSCODE.
- Candidate capture: on `rdy` & key 8 & `ValidNewUC`, candidate ← buffer.
- UC commit: on the first cycle `Chillin` is high (rising edge), UC ← candidate.
- `locked` toggles on each rising edge of `ToggleLED1`.

## Timing
- Reset values: buffer 0, `entry_cnt` 0, `ovf` 0, candidate 0, UC = DEFAULT_UC, `locked` 0, `lockout` 0, previous mode IDLE.
- With reset values, `match` = 0 and `ValidNewUC` = 0.
- Digit latency: a digit on `rdy` in cycle n is visible in buffer, `entry_cnt` and `match` in cycle n+1.
- The command-key cycle sees the pre-clear buffer: `match` and `ValidNewUC` are valid in the same cycle the FSM samples them. The clear takes effect at the next edge.
- Simultaneous command key and mode change: single clear, no digit shift.
- Simultaneous `Chillin` rise and key: commit proceeds; the key is ignored (IDLE mode).
- `rdy` held high across several cycles: every cycle counts as a press. Debouncing is upstream.
- Mid-operation reset: all state returns to reset values immediately; a committed UC reverts to DEFAULT_UC.

## Configuration
- `KEYPAD_CODE_LOCKOUT_EN` defined:
  - A 2-bit counter counts rising edges of `error`.
  - On the third edge, `lockout` asserts for exactly LOCKOUT_CYCLES clocks and the counter clears.
  - While `lockout` is high, digits are ignored and `match` is forced to 0.
  - A rising edge of `ToggleLED1` also clears the counter.
- Macro undefined: no counter, `lockout` is tied 0, behaviour is otherwise identical.

## Structure
- Package `keylock_pkg` holds:
  - key constants `KEY_CANCEL`=7, `KEY_PROG`=8, `KEY_LOCK`=9;
  - mode enum `code_mode_e` (IDLE, PC, VALID, CONFIRM, UC);
  - default `CODE_LEN`.
- Sub-module `code_entry_buffer` contains the shift register, `entry_cnt` and `ovf`, with inputs shift, digit and clear. Target selection, compare, candidate, UC, `locked` and lockout stay in the top.

## Test plan
- Unlock: hold `LOCKING`=1, press 5,A,B,0, then 9 → `match`=1 in the cycle 9 is strobed; next cycle `entry_cnt`=0 and `match`=0.
- Overflow: `LOCKING`=1, press 5,A,B,0,1 → `ovf` set, `match`=0 while `entry_cnt` stays 4; press 9 → cleared.
- Programming flow:
  - PC mode, press 1,2,3,4,8 → `match`=1.
  - VALID mode, press 6,5,4,3,8 → `ValidNewUC`=1 and candidate=16'h6543.
  - CONFIRM mode, press 6,5,4,3 → `match`=1.
  - `Chillin` pulse → UC=16'h6543.
  - Old code 5AB0 no longer matches.
- Invalid candidate: VALID mode, enter 1,2,3,4 (equals PASSCODE) → `ValidNewUC`=0; 3 digits → `ValidNewUC`=0.
- Mode change mid-entry: `LOCKING`, press 1,2; drop to IDLE → `entry_cnt`=0 next cycle. Reset mid-entry → UC=16'h5AB0 and `locked`=0.
- Lockout (macro on): three `error` pulses → `lockout`=1 for 1000 cycles; digits during lockout leave `entry_cnt`=0.

Source files
------------

// File: rtl/keylock_pkg.sv
// Shared key codes, entry modes and default code length for the keypad code engine.
package keylock_pkg;

  localparam int CODE_LEN = 4;

  localparam logic [3:0] KEY_CANCEL = 4'd7;
  localparam logic [3:0] KEY_PROG   = 4'd8;
  localparam logic [3:0] KEY_LOCK   = 4'd9;

  typedef enum logic [2:0] {
    MODE_IDLE,
    MODE_PC,
    MODE_VALID,
    MODE_CONFIRM,
    MODE_UC
  } code_mode_e;

  function automatic logic is_cmd_key(input logic [3:0] key);
    return (key == KEY_CANCEL) || (key == KEY_PROG) || (key == KEY_LOCK);
  endfunction

endpackage

// File: rtl/keypad_code_engine_if.sv
// Key strobe, FSM state bits and code qualifiers between the keylock FSM side and the engine.
interface keypad_code_engine_if #(
  parameter int CODE_LEN = keylock_pkg::CODE_LEN
);
  localparam int CW = $clog2(CODE_LEN + 1);

  logic          rdy;
  logic [3:0]    keypress;
  logic          CheckPC;
  logic          CheckValidUC;
  logic          confirmUC;
  logic          LOCKING;
  logic          ToggleLED1;
  logic          Chillin;
  logic          error;
  logic          match;
  logic          ValidNewUC;
  logic          locked;
  logic [CW-1:0] entry_cnt;
  logic          lockout;

  modport master (
    output rdy, keypress, CheckPC, CheckValidUC, confirmUC, LOCKING, ToggleLED1, Chillin, error,
    input  match, ValidNewUC, locked, entry_cnt, lockout
  );

  modport slave (
    input  rdy, keypress, CheckPC, CheckValidUC, confirmUC, LOCKING, ToggleLED1, Chillin, error,
    output match, ValidNewUC, locked, entry_cnt, lockout
  );

endinterface

// File: rtl/code_entry_buffer.sv
// Digit shift register with entry count and sticky overflow; updates one clock after shift/clear.
// Clear wins over shift; a digit arriving when full only sets ovf and leaves the buffer intact.
module code_entry_buffer #(
  parameter int CODE_LEN = keylock_pkg::CODE_LEN,
  localparam int W  = 4 * CODE_LEN,
  localparam int CW = $clog2(CODE_LEN + 1)
) (
  input  logic          clk,
  input  logic          resetN,
  input  logic          shift_i,
  input  logic [3:0]    digit_i,
  input  logic          clear_i,
  output logic [W-1:0]  buf_o,
  output logic [CW-1:0] cnt_o,
  output logic          ovf_o
);

  logic [W-1:0]  buf_q, buf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;

  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clear_i) begin
      buf_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (shift_i) begin
      if (cnt_q == CW'(CODE_LEN)) begin
        ovf_d = 1'b1;
      end else begin
        buf_d = {buf_q[W-5:0], digit_i};
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      buf_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign buf_o = buf_q;
  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/keypad_code_engine.sv
// Keylock datapath: digit entry, code compare, candidate/UC storage and lock status.
// match/ValidNewUC are combinational from registers; optional lockout under KEYPAD_CODE_LOCKOUT_EN.
module keypad_code_engine
  import keylock_pkg::*;
#(
  parameter int                  CODE_LEN       = keylock_pkg::CODE_LEN,
  parameter logic [4*CODE_LEN-1:0] PASSCODE     = 16'h1234,
  parameter logic [4*CODE_LEN-1:0] DEFAULT_UC   = 16'h5AB0,
  parameter int                  LOCKOUT_CYCLES = 1000
) (
  input  logic                 clk,
  input  logic                 resetN,
  keypad_code_engine_if.slave  bus
);

  localparam int W  = 4 * CODE_LEN;
  localparam int CW = $clog2(CODE_LEN + 1);

  code_mode_e    mode, prev_mode_q;
  logic [W-1:0]  entry, target, cand_q, uc_q;
  logic [CW-1:0] cnt;
  logic          ovf, clear, shift, full_ok, has_target, valid_new;
  logic          chillin_q, toggle_q, locked_q, lockout_act;

  always_comb begin
    mode = MODE_IDLE;
    if (bus.CheckPC)           mode = MODE_PC;
    else if (bus.CheckValidUC) mode = MODE_VALID;
    else if (bus.confirmUC)    mode = MODE_CONFIRM;
    else if (bus.LOCKING)      mode = MODE_UC;
  end

  // Any clear cause suppresses the shift, so a command key coinciding with a mode change clears once.
  assign clear = (bus.rdy && is_cmd_key(bus.keypress)) || (mode != prev_mode_q) || (mode == MODE_IDLE);
  assign shift = bus.rdy && !is_cmd_key(bus.keypress) && (mode != MODE_IDLE) && !lockout_act;

  code_entry_buffer #(.CODE_LEN(CODE_LEN)) u_buf (
    .clk     (clk),
    .resetN  (resetN),
    .shift_i (shift),
    .digit_i (bus.keypress),
    .clear_i (clear),
    .buf_o   (entry),
    .cnt_o   (cnt),
    .ovf_o   (ovf)
  );

  always_comb begin
    target     = '0;
    has_target = 1'b0;
    case (mode)
      MODE_PC:      begin target = PASSCODE; has_target = 1'b1; end
      MODE_UC:      begin target = uc_q;     has_target = 1'b1; end
      MODE_CONFIRM: begin target = cand_q;   has_target = 1'b1; end
      default:      begin target = '0;       has_target = 1'b0; end
    endcase
  end

  assign full_ok   = (cnt == CW'(CODE_LEN)) && !ovf;
  assign valid_new = (mode == MODE_VALID) && full_ok && (entry != PASSCODE);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      prev_mode_q <= MODE_IDLE;
      cand_q      <= '0;
      uc_q        <= DEFAULT_UC;
      chillin_q   <= 1'b0;
      toggle_q    <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      prev_mode_q <= mode;
      chillin_q   <= bus.Chillin;
      toggle_q    <= bus.ToggleLED1;
      if (bus.rdy && (bus.keypress == KEY_PROG) && valid_new) cand_q <= entry;
      if (bus.Chillin && !chillin_q)                          uc_q   <= cand_q;
      if (bus.ToggleLED1 && !toggle_q)                        locked_q <= !locked_q;
    end
  end

`ifdef KEYPAD_CODE_LOCKOUT_EN
  localparam int TW = $clog2(LOCKOUT_CYCLES + 1);

  logic          error_q, lockout_q;
  logic [1:0]    err_cnt_q;
  logic [TW-1:0] tmr_q;

  // Timer is preloaded with LOCKOUT_CYCLES-1 so lockout stays high for exactly LOCKOUT_CYCLES clocks.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      error_q   <= 1'b0;
      lockout_q <= 1'b0;
      err_cnt_q <= '0;
      tmr_q     <= '0;
    end else begin
      error_q <= bus.error;
      if (bus.error && !error_q) begin
        if (err_cnt_q == 2'd2) begin
          err_cnt_q <= '0;
          lockout_q <= 1'b1;
          tmr_q     <= TW'(LOCKOUT_CYCLES - 1);
        end else begin
          err_cnt_q <= err_cnt_q + 2'd1;
        end
      end else if (bus.ToggleLED1 && !toggle_q) begin
        err_cnt_q <= '0;
      end
      if (lockout_q && !(bus.error && !error_q && err_cnt_q == 2'd2)) begin
        if (tmr_q == '0) lockout_q <= 1'b0;
        else             tmr_q     <= tmr_q - 1'b1;
      end
    end
  end

  assign lockout_act = lockout_q;
`else
  assign lockout_act = 1'b0;
`endif

  assign bus.match      = full_ok && has_target && (entry == target) && !lockout_act;
  assign bus.ValidNewUC = valid_new;
  assign bus.locked     = locked_q;
  assign bus.entry_cnt  = cnt;
  assign bus.lockout    = lockout_act;

endmodule

// File: tb/tb_keypad_code_engine.sv
// Directed bench for keypad_code_engine; stimulus changes 1ns after each rising edge, checks follow it.
module tb_keypad_code_engine;
  import keylock_pkg::*;

  logic clk = 1'b0;
  logic resetN;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  keypad_code_engine_if #(.CODE_LEN(4)) kif ();

  keypad_code_engine dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (kif)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    kif.rdy      = 1'b1;
    kif.keypress = k;
    tick();
    kif.rdy      = 1'b0;
  endtask

  task automatic set_mode(input logic pc, input logic vu, input logic cf, input logic lk);
    kif.CheckPC      = pc;
    kif.CheckValidUC = vu;
    kif.confirmUC    = cf;
    kif.LOCKING      = lk;
    tick();
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    kif.rdy = 0; kif.keypress = 0; kif.CheckPC = 0; kif.CheckValidUC = 0; kif.confirmUC = 0;
    kif.LOCKING = 0; kif.ToggleLED1 = 0; kif.Chillin = 0; kif.error = 0;
    #12;
    n_chk++; if (kif.match !== 1'b0) $display("FAIL reset_match got=%0b exp=0", kif.match); else n_pass++;
    n_chk++; if (kif.ValidNewUC !== 1'b0) $display("FAIL reset_valid got=%0b exp=0", kif.ValidNewUC); else n_pass++;
    n_chk++; if (kif.entry_cnt !== 3'd0) $display("FAIL reset_cnt got=%0d exp=0", kif.entry_cnt); else n_pass++;
    n_chk++; if (kif.locked !== 1'b0) $display("FAIL reset_locked got=%0b exp=0", kif.locked); else n_pass++;
    n_chk++; if (kif.lockout !== 1'b0) $display("FAIL reset_lockout got=%0b exp=0", kif.lockout); else n_pass++;
    resetN = 1'b1;
    tick();
  endtask

  task automatic test_unlock();
    set_mode(0, 0, 0, 1);
    press(4'h5); press(4'hA); press(4'hB);
    n_chk++; if (kif.match !== 1'b0) $display("FAIL unlock_partial_match got=%0b exp=0", kif.match); else n_pass++;
    n_chk++; if (kif.entry_cnt !== 3'd3) $display("FAIL unlock_partial_cnt got=%0d exp=3", kif.entry_cnt); else n_pass++;
    press(4'h0);
    n_chk++; if (kif.entry_cnt !== 3'd4) $display("FAIL unlock_cnt got=%0d exp=4", kif.entry_cnt); else n_pass++;
    kif.rdy = 1'b1; kif.keypress = KEY_LOCK;
    #1;
    n_chk++; if (kif.match !== 1'b1) $display("FAIL unlock_match_on_cmd got=%0b exp=1", kif.match); else n_pass++;
    tick();
    kif.rdy = 1'b0;
    n_chk++; if (kif.entry_cnt !== 3'd0) $display("FAIL unlock_clear_cnt got=%0d exp=0", kif.entry_cnt); else n_pass++;
    n_chk++; if (kif.match !== 1'b0) $display("FAIL unlock_clear_match got=%0b exp=0", kif.match); else n_pass++;
  endtask

  task automatic test_overflow();
    press(4'h5); press(4'hA); press(4'hB); press(4'h0); press(4'h1);
    n_chk++; if (kif.entry_cnt !== 3'd4) $display("FAIL ovf_cnt got=%0d exp=4", kif.entry_cnt); else n_pass++;
    n_chk++; if (kif.match !== 1'b0) $display("FAIL ovf_match got=%0b exp=0", kif.match); else n_pass++;
    press(KEY_LOCK);
    n_chk++; if (kif.entry_cnt !== 3'd0) $display("FAIL ovf_clear_cnt got=%0d exp=0", kif.entry_cnt); else n_pass++;
    press(4'h5); press(4'hA); press(4'hB); press(4'h0);
    n_chk++; if (kif.match !== 1'b1) $display("FAIL ovf_recover_match got=%0b exp=1", kif.match); else n_pass++;
    press(KEY_CANCEL);
  endtask

  task automatic test_program();
    set_mode(1, 0, 0, 0);
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    n_chk++; if (kif.match !== 1'b1) $display("FAIL prog_pc_match got=%0b exp=1", kif.match); else n_pass++;
    press(KEY_PROG);
    set_mode(0, 1, 0, 0);
    press(4'h6); press(4'h5); press(4'h4); press(4'h3);
    n_chk++; if (kif.ValidNewUC !== 1'b1) $display("FAIL prog_valid got=%0b exp=1", kif.ValidNewUC); else n_pass++;
    n_chk++; if (kif.match !== 1'b0) $display("FAIL prog_valid_mode_match got=%0b exp=0", kif.match); else n_pass++;
    press(KEY_PROG);
    set_mode(0, 0, 1, 0);
    press(4'h6); press(4'h5); press(4'h4); press(4'h3);
    n_chk++; if (kif.match !== 1'b1) $display("FAIL prog_confirm_match got=%0b exp=1", kif.match); else n_pass++;
    kif.confirmUC = 1'b0; kif.Chillin = 1'b1;
    press(4'h5);
    n_chk++; if (kif.entry_cnt !== 3'd0) $display("FAIL prog_chillin_key_cnt got=%0d exp=0", kif.entry_cnt); else n_pass++;
    tick();
    kif.Chillin = 1'b0;
    set_mode(0, 0, 0, 1);
    press(4'h6); press(4'h5); press(4'h4); press(4'h3);
    n_chk++; if (kif.match !== 1'b1) $display("FAIL prog_new_uc_match got=%0b exp=1", kif.match); else n_pass++;
    press(KEY_CANCEL);
    press(4'h5); press(4'hA); press(4'hB); press(4'h0);
    n_chk++; if (kif.match !== 1'b0) $display("FAIL prog_old_uc_match got=%0b exp=0", kif.match); else n_pass++;
    press(KEY_CANCEL);
  endtask

  task automatic test_invalid_candidate();
    set_mode(0, 1, 0, 0);
    press(4'h1); press(4'h2); press(4'h3);
    n_chk++; if (kif.ValidNewUC !== 1'b0) $display("FAIL inv_3digit got=%0b exp=0", kif.ValidNewUC); else n_pass++;
    press(4'h4);
    n_chk++; if (kif.ValidNewUC !== 1'b0) $display("FAIL inv_passcode got=%0b exp=0", kif.ValidNewUC); else n_pass++;
    press(KEY_CANCEL);
    press(4'h1); press(4'h2); press(4'h3); press(4'h5);
    n_chk++; if (kif.ValidNewUC !== 1'b1) $display("FAIL inv_other_code got=%0b exp=1", kif.ValidNewUC); else n_pass++;
    press(KEY_CANCEL);
  endtask

  task automatic test_mode_change();
    set_mode(0, 0, 0, 1);
    press(4'h1); press(4'h2);
    n_chk++; if (kif.entry_cnt !== 3'd2) $display("FAIL mode_pre_cnt got=%0d exp=2", kif.entry_cnt); else n_pass++;
    set_mode(0, 0, 0, 0);
    n_chk++; if (kif.entry_cnt !== 3'd0) $display("FAIL mode_idle_cnt got=%0d exp=0", kif.entry_cnt); else n_pass++;
    set_mode(0, 0, 0, 1);
    press(4'h1);
    kif.CheckPC = 1'b1;
    press(KEY_LOCK);
    n_chk++; if (kif.entry_cnt !== 3'd0) $display("FAIL mode_cmd_change_cnt got=%0d exp=0", kif.entry_cnt); else n_pass++;
    press(4'h1);
    n_chk++; if (kif.entry_cnt !== 3'd1) $display("FAIL mode_after_change_cnt got=%0d exp=1", kif.entry_cnt); else n_pass++;
  endtask

  task automatic test_back_to_back();
    set_mode(0, 0, 0, 1);
    kif.rdy = 1'b1; kif.keypress = 4'h3;
    tick(); tick(); tick();
    kif.rdy = 1'b0;
    n_chk++; if (kif.entry_cnt !== 3'd3) $display("FAIL b2b_cnt got=%0d exp=3", kif.entry_cnt); else n_pass++;
    press(KEY_CANCEL);
  endtask

  task automatic test_locked_toggle();
    kif.ToggleLED1 = 1'b1; tick(); tick();
    n_chk++; if (kif.locked !== 1'b1) $display("FAIL toggle_first got=%0b exp=1", kif.locked); else n_pass++;
    kif.ToggleLED1 = 1'b0; tick();
    kif.ToggleLED1 = 1'b1; tick();
    kif.ToggleLED1 = 1'b0;
    n_chk++; if (kif.locked !== 1'b0) $display("FAIL toggle_second got=%0b exp=0", kif.locked); else n_pass++;
    kif.ToggleLED1 = 1'b1; tick();
    kif.ToggleLED1 = 1'b0;
  endtask

  task automatic test_reset_mid();
    set_mode(0, 0, 0, 1);
    press(4'h1); press(4'h2);
    resetN = 1'b0;
    #1;
    n_chk++; if (kif.entry_cnt !== 3'd0) $display("FAIL rst_mid_cnt got=%0d exp=0", kif.entry_cnt); else n_pass++;
    n_chk++; if (kif.locked !== 1'b0) $display("FAIL rst_mid_locked got=%0b exp=0", kif.locked); else n_pass++;
    #2;
    resetN = 1'b1;
    tick(); tick();
    press(4'h5); press(4'hA); press(4'hB); press(4'h0);
    n_chk++; if (kif.match !== 1'b1) $display("FAIL rst_mid_default_uc got=%0b exp=1", kif.match); else n_pass++;
    press(KEY_CANCEL);
  endtask

  task automatic test_lockout();
    int hi_cnt;
    set_mode(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      kif.error = 1'b1; tick();
      kif.error = 1'b0; tick();
    end
`ifdef KEYPAD_CODE_LOCKOUT_EN
    // Lockout asserted at the third error edge, two clocks ago.
    n_chk++; if (kif.lockout !== 1'b1) $display("FAIL lockout_assert got=%0b exp=1", kif.lockout); else n_pass++;
    hi_cnt = 2;
    press(4'h1);
    hi_cnt++;
    n_chk++; if (kif.entry_cnt !== 3'd0) $display("FAIL lockout_digit_cnt got=%0d exp=0", kif.entry_cnt); else n_pass++;
    for (int i = 0; i < 1100; i++) begin
      if (kif.lockout !== 1'b1) break;
      tick();
      if (kif.lockout === 1'b1) hi_cnt++;
    end
    n_chk++; if (hi_cnt !== 1000) $display("FAIL lockout_len got=%0d exp=1000", hi_cnt); else n_pass++;
`else
    hi_cnt = 0;
    n_chk++; if (kif.lockout !== 1'b0) $display("FAIL lockout_off got=%0b exp=0", kif.lockout); else n_pass++;
`endif
    press(4'h1);
    n_chk++; if (kif.entry_cnt !== 3'd1) $display("FAIL lockout_after_cnt got=%0d exp=1 (hi=%0d)", kif.entry_cnt, hi_cnt); else n_pass++;
    press(KEY_CANCEL);
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_overflow();
    test_program();
    test_invalid_candidate();
    test_mode_change();
    test_back_to_back();
    test_locked_toggle();
    test_reset_mid();
    test_lockout();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
